// File: rtl/dcpu16_wbmem_pkg.sv
// Shared constants for the DCPU16 Wishbone-style RAM: port FSM encodings,
// wait-counter width and the round-robin port identifier.
package dcpu16_wbmem_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_G = 1'b1
  } port_e;

  function automatic logic [CNT_W-1:0] wait_load(input int w);
    return CNT_W'(w);
  endfunction

endpackage

// File: rtl/dcpu16_wbmem_if.sv
// Fetch (F) and data (G) bus signals of the DCPU16 RAM, bundled for the
// CPU side (master) and the memory side (slave).
interface dcpu16_wbmem_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic [AW-1:0] f_adr;
  logic [DW-1:0] f_dti;
  logic [DW-1:0] f_dto;
  logic          f_stb;
  logic          f_wre;
  logic          f_ack;

  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dti;
  logic [DW-1:0] g_dto;
  logic          g_stb;
  logic          g_wre;
  logic          g_ack;

  modport master (
    output f_adr, f_dti, f_stb, f_wre,
    input  f_dto, f_ack,
    output g_adr, g_dti, g_stb, g_wre,
    input  g_dto, g_ack
  );

  modport slave (
    input  f_adr, f_dti, f_stb, f_wre,
    output f_dto, f_ack,
    input  g_adr, g_dti, g_stb, g_wre,
    output g_dto, g_ack
  );

endinterface

// File: rtl/dcpu16_wbport.sv
// Per-port handshake FSM: accepts a granted request, waits WAIT cycles,
// then raises ack for exactly one cycle.
module dcpu16_wbport
  import dcpu16_wbmem_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic accept,
  output logic ack,
  output logic idle
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign idle   = (state == ST_IDLE);
  assign accept = idle & req & ~rst;
  assign ack    = (state == ST_ACK);

  // Requests arriving while in WAIT or ACK are ignored; the master keeps stb up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (WAIT == 0) begin
              state <= ST_ACK;
            end else begin
              state <= ST_WAIT;
              cnt   <= wait_load(WAIT);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcpu16_wbmem.sv
// Two-port synchronous RAM for the DCPU16 core with internal stb/ack handshake,
// per-port wait states and an optional single-array round-robin mode.
module dcpu16_wbmem
  import dcpu16_wbmem_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int FWAIT  = 0,
  parameter int GWAIT  = 0,
  parameter int SHARED = 0
) (
  input  logic           clk,
  input  logic           rst,
  dcpu16_wbmem_if.slave  bus
);

  localparam bit ARB = (SHARED != 0);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] f_dto_q;
  logic [DW-1:0] g_dto_q;

  logic  f_req, g_req;
  logic  f_accept, g_accept;
  logic  f_ack, g_ack;
  logic  f_idle, g_idle;
  logic  contend;
  port_e prio;

  // Contention only exists in shared mode when both idle ports request together.
  assign contend = ARB & bus.f_stb & f_idle & bus.g_stb & g_idle;
  assign f_req   = bus.f_stb & (~contend | (prio == PORT_F));
  assign g_req   = bus.g_stb & (~contend | (prio == PORT_G));

  dcpu16_wbport #(.WAIT(FWAIT)) uf0 (
    .clk    (clk),
    .rst    (rst),
    .req    (f_req),
    .accept (f_accept),
    .ack    (f_ack),
    .idle   (f_idle)
  );

  dcpu16_wbport #(.WAIT(GWAIT)) ug0 (
    .clk    (clk),
    .rst    (rst),
    .req    (g_req),
    .accept (g_accept),
    .ack    (g_ack),
    .idle   (g_idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PORT_F;
    end else if (f_accept) begin
      prio <= PORT_G;
    end else if (g_accept) begin
      prio <= PORT_F;
    end
  end

  // G is written last so it wins a same-address write collision.
  always_ff @(posedge clk) begin
    if (f_accept && bus.f_wre) begin
      mem[bus.f_adr] <= bus.f_dti;
    end
    if (g_accept && bus.g_wre) begin
      mem[bus.g_adr] <= bus.g_dti;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_dto_q <= '0;
      g_dto_q <= '0;
    end else begin
      if (f_accept && !bus.f_wre) begin
        f_dto_q <= mem[bus.f_adr];
      end
      if (g_accept && !bus.g_wre) begin
        g_dto_q <= mem[bus.g_adr];
      end
    end
  end

  assign bus.f_dto = f_dto_q;
  assign bus.g_dto = g_dto_q;
  assign bus.f_ack = f_ack;
  assign bus.g_ack = g_ack;

endmodule

// File: tb/tb_dcpu16_wbmem.sv
// Bench for dcpu16_wbmem: three configurations driven by directed and random
// masters, compared each cycle against a transaction-level reference model.
module tb_dcpu16_wbmem;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ND = 3;
  localparam int FWV [ND] = '{0, 2, 0};
  localparam int GWV [ND] = '{0, 5, 0};
  localparam int SHV [ND] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          stb   [ND][2];
  logic          wre   [ND][2];
  logic [AW-1:0] adr   [ND][2];
  logic [DW-1:0] dti   [ND][2];
  logic          ack_o [ND][2];
  logic [DW-1:0] dto_o [ND][2];

  logic [DW-1:0] mmem      [ND][1<<AW];
  int            next_free [ND][2];
  int            ack_at    [ND][2];
  logic [DW-1:0] exp_dto   [ND][2];
  bit            prefer_f  [ND];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < ND; i++) begin : g_dut
      dcpu16_wbmem_if #(.AW(AW), .DW(DW)) bus ();

      assign bus.f_stb = stb[i][0];
      assign bus.f_wre = wre[i][0];
      assign bus.f_adr = adr[i][0];
      assign bus.f_dti = dti[i][0];
      assign bus.g_stb = stb[i][1];
      assign bus.g_wre = wre[i][1];
      assign bus.g_adr = adr[i][1];
      assign bus.g_dti = dti[i][1];
      assign ack_o[i][0] = bus.f_ack;
      assign ack_o[i][1] = bus.g_ack;
      assign dto_o[i][0] = bus.f_dto;
      assign dto_o[i][1] = bus.g_dto;

      dcpu16_wbmem #(
        .AW(AW), .DW(DW), .FWAIT(FWV[i]), .GWAIT(GWV[i]), .SHARED(SHV[i])
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic applyStimulus(input int d, input int p, input logic s, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] v);
    stb[d][p] = s;
    wre[d][p] = w;
    adr[d][p] = a;
    dti[d][p] = v;
  endtask

  // Reference model: an accepted request is acked WAIT cycles after the accept
  // edge and the port may accept again two cycles after that.
  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit cand [2];
      int w;
      if (rst) begin
        prefer_f[d] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          ack_at[d][p]    = -10;
          next_free[d][p] = cyc + 1;
          exp_dto[d][p]   = '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) cand[p] = stb[d][p] && (cyc >= next_free[d][p]);
        if (SHV[d] != 0 && cand[0] && cand[1]) begin
          if (prefer_f[d]) cand[1] = 1'b0;
          else cand[0] = 1'b0;
        end
        for (int p = 0; p < 2; p++)
          if (cand[p] && !wre[d][p]) exp_dto[d][p] = mmem[d][adr[d][p]];
        for (int p = 0; p < 2; p++)
          if (cand[p] && wre[d][p]) mmem[d][adr[d][p]] = dti[d][p];
        for (int p = 0; p < 2; p++) begin
          if (cand[p]) begin
            w = (p == 0) ? FWV[d] : GWV[d];
            ack_at[d][p]    = cyc + w;
            next_free[d][p] = cyc + w + 2;
            prefer_f[d]     = (p == 1);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("d%0d_%s_ack", d, p ? "g" : "f"), 32'(ack_o[d][p]), 32'(ack_at[d][p] == cyc));
        checkOutput($sformatf("d%0d_%s_dto", d, p ? "g" : "f"), 32'(dto_o[d][p]), 32'(exp_dto[d][p]));
      end
    end
  endtask

  task automatic wait_ack(input int d, input int p, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ack_o[d][p]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic drop_all();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 2; p++) stb[d][p] = 1'b0;
  endtask

  task automatic pulse_reset();
    drop_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    for (int d = 0; d < ND; d++) begin
      prefer_f[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        applyStimulus(d, p, 1'b0, 1'b0, '0, '0);
        ack_at[d][p]    = -10;
        next_free[d][p] = 0;
        exp_dto[d][p]   = '0;
      end
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      for (int a = 0; a < 16; a++) begin
        applyStimulus(d, 1, 1'b1, 1'b1, AW'(a), DW'($urandom));
        wait_ack(d, 1, n);
        checkOutput("init_ack", 32'(n > 0), 32'd1);
        stb[d][1] = 1'b0;
      end
    end

    // Back-to-back fetches with stb held high on a zero-wait port.
    applyStimulus(0, 1, 1'b1, 1'b1, AW'('h10), 16'hBEEF);
    wait_ack(0, 1, n);
    stb[0][1] = 1'b0;
    applyStimulus(0, 0, 1'b1, 1'b0, AW'('h10), '0);
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput("t1_ack", 32'(ack_o[0][0]), 32'(k % 2));
      if (ack_o[0][0]) begin
        cnt++;
        checkOutput("t1_dto", 32'(dto_o[0][0]), 32'hBEEF);
      end
    end
    checkOutput("t1_count", 32'(cnt), 32'd3);
    stb[0][0] = 1'b0;
    step();

    applyStimulus(1, 1, 1'b1, 1'b1, AW'('h20), 16'h1234);
    wait_ack(1, 1, n);
    checkOutput("t2_g_lat", 32'(n), 32'd6);
    stb[1][1] = 1'b0;
    applyStimulus(1, 0, 1'b1, 1'b0, AW'('h20), '0);
    wait_ack(1, 0, n);
    checkOutput("t2_f_lat", 32'(n), 32'd3);
    checkOutput("t2_dto", 32'(dto_o[1][0]), 32'h1234);
    stb[1][0] = 1'b0;
    step();

    applyStimulus(0, 0, 1'b1, 1'b1, AW'('h30), 16'hAAAA);
    applyStimulus(0, 1, 1'b1, 1'b1, AW'('h30), 16'h5555);
    step();
    checkOutput("t3_f_ack", 32'(ack_o[0][0]), 32'd1);
    checkOutput("t3_g_ack", 32'(ack_o[0][1]), 32'd1);
    drop_all();
    applyStimulus(0, 0, 1'b1, 1'b0, AW'('h30), '0);
    wait_ack(0, 0, n);
    checkOutput("t3_dto", 32'(dto_o[0][0]), 32'h5555);
    stb[0][0] = 1'b0;
    step();

    applyStimulus(0, 1, 1'b1, 1'b1, AW'('h40), 16'h1111);
    wait_ack(0, 1, n);
    stb[0][1] = 1'b0;
    step();
    applyStimulus(0, 0, 1'b1, 1'b0, AW'('h40), '0);
    applyStimulus(0, 1, 1'b1, 1'b1, AW'('h40), 16'h2222);
    step();
    checkOutput("t4_old", 32'(dto_o[0][0]), 32'h1111);
    drop_all();
    step();
    applyStimulus(0, 0, 1'b1, 1'b0, AW'('h40), '0);
    wait_ack(0, 0, n);
    checkOutput("t4_new", 32'(dto_o[0][0]), 32'h2222);
    stb[0][0] = 1'b0;

    // Shared array: both ports held high must alternate starting with F.
    pulse_reset();
    applyStimulus(2, 0, 1'b1, 1'b0, AW'(1), '0);
    applyStimulus(2, 1, 1'b1, 1'b0, AW'(2), '0);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("t5_f", 32'(ack_o[2][0]), 32'(k % 2));
      checkOutput("t5_g", 32'(ack_o[2][1]), 32'((k + 1) % 2));
    end
    drop_all();
    step();

    applyStimulus(1, 1, 1'b1, 1'b1, AW'('h50), 16'h6A6A);
    step();
    step();
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      checkOutput("t6_ack", 32'(ack_o[1][1]), 32'd0);
      checkOutput("t6_dto", 32'(dto_o[1][1]), 32'd0);
    end
    applyStimulus(1, 1, 1'b1, 1'b0, AW'('h50), '0);
    wait_ack(1, 1, n);
    checkOutput("t6_lat", 32'(n), 32'd6);
    checkOutput("t6_dto_kept", 32'(dto_o[1][1]), 32'h6A6A);
    stb[1][1] = 1'b0;
    step();

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        drop_all();
        rst = 1'b1;
      end else begin
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
          for (int p = 0; p < 2; p++) begin
            if (stb[d][p] && ack_o[d][p]) begin
              if ($urandom_range(0, 1) == 1)
                applyStimulus(d, p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
              else
                stb[d][p] = 1'b0;
            end else if (!stb[d][p] && $urandom_range(0, 2) == 0) begin
              applyStimulus(d, p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
          end
        end
      end
      step();
    end
    rst = 1'b0;
    drop_all();
    for (int k = 0; k < 10; k++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
